imem_port_arbiter: RTL

//  Shares the single 32x16 program/data memory (one access per cycle) between the fetch

---
 rtl/imem_port_arbiter_if.sv | 60 ++++++
 rtl/imem_port_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter_if
// Purpose  : Bundles the fetch port, memory-stage port and the shared
//            single-port memory pins handled by imem_port_arbiter.
// Modports : slave  - arbiter side (takes requests and read data,
//                     drives stalls, responses and memory pins)
//            master - requester/memory side (the reverse directions)
// Signals  : if_req/if_addr/if_stall/if_rdata/if_rvalid        fetch port
//            dm_req/dm_we/dm_addr/dm_wdata/dm_stall/dm_rdata/dm_rvalid
//                                                              memory-stage port
//            mem_read_enable/mem_write_enable/mem_read_addr/mem_write_addr/
//            mem_write_data/mem_read_data                      memory pins
// Revision : 1.0 - initial release
// ============================================================================
interface imem_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  // fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_stall;
  logic [DW-1:0] if_rdata;
  logic          if_rvalid;
  // memory-stage port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_stall;
  logic [DW-1:0] dm_rdata;
  logic          dm_rvalid;
  // shared memory pins
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [AW-1:0] mem_read_addr;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;

  modport slave (
    input  if_req, if_addr,
    output if_stall, if_rdata, if_rvalid,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_stall, dm_rdata, dm_rvalid,
    output mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output if_req, if_addr,
    input  if_stall, if_rdata, if_rvalid,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_stall, dm_rdata, dm_rvalid,
    input  mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
    output mem_read_data
  );
endinterface
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_port_arbiter
// Purpose  : Shares one single-port program/data memory between the fetch
//            stage (reads) and the memory stage (loads/stores). One grant per
//            cycle, memory-stage priority, registered owner tag routes the
//            read word (1-cycle latency) back to the requester that issued it.
// Ports    : clk  - system clock (rising edge)
//            rst  - synchronous active-high reset
//            bus  - imem_port_arbiter_if.slave: fetch port, memory-stage
//                   port and memory pins
// Params   : AW (address width), DW (data width), STARVE_MAX (denied fetch
//            cycles before a forced fetch grant, guard build only)
// Config   : ARB_STARVE_GUARD_EN - when defined, a saturating starvation
//            counter forces a fetch grant after STARVE_MAX denied cycles.
//            Undefined: strict memory-stage priority.
// Revision : 1.0 - initial release
// ============================================================================
module imem_port_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  imem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_DM   = 2'd2
  } rsp_t;

  rsp_t          rsp_state;
  rsp_t          rsp_next;

  logic          force_if;
  logic          grant_if;
  logic          grant_dm;
  logic          grant_load;
  logic          grant_store;
  logic          grant_read;

  logic [AW-1:0] hold_read_addr;
  logic [AW-1:0] hold_write_addr;
  logic [DW-1:0] hold_write_data;

  // --------------------------------------------------------------------------
  // Starvation guard
  // --------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
  localparam int            CW           = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // Counts consecutive cycles in which fetch asked but lost; any fetch grant
  // or an idle fetch port restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if || !bus.if_req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign force_if = bus.if_req && bus.dm_req && (starve_cnt == STARVE_LIMIT);
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^STARVE_MAX;
  assign force_if          = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant decision (combinational, same cycle as the request)
  // --------------------------------------------------------------------------
  assign grant_dm    = !rst && bus.dm_req && !force_if;
  assign grant_if    = !rst && bus.if_req && (!bus.dm_req || force_if);
  assign grant_load  = grant_dm && !bus.dm_we;
  assign grant_store = grant_dm &&  bus.dm_we;
  assign grant_read  = grant_if || grant_load;

  // Reset forces both stalls high regardless of the request lines.
  assign bus.if_stall = rst || (bus.if_req && !grant_if);
  assign bus.dm_stall = rst || (bus.dm_req && !grant_dm);

  // --------------------------------------------------------------------------
  // Memory pins: address/data hold their last driven value when idle so the
  // memory never sees X on its address/data inputs.
  // --------------------------------------------------------------------------
  assign bus.mem_read_enable  = grant_read;
  assign bus.mem_write_enable = grant_store;
  assign bus.mem_read_addr    = grant_if    ? bus.if_addr  :
                                grant_load  ? bus.dm_addr  : hold_read_addr;
  assign bus.mem_write_addr   = grant_store ? bus.dm_addr  : hold_write_addr;
  assign bus.mem_write_data   = grant_store ? bus.dm_wdata : hold_write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_read_addr  <= '0;
      hold_write_addr <= '0;
      hold_write_data <= '0;
    end else begin
      if (grant_read) begin
        hold_read_addr <= bus.mem_read_addr;
      end
      if (grant_store) begin
        hold_write_addr <= bus.dm_addr;
        hold_write_data <= bus.dm_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response owner FSM: remembers who issued last cycle's read
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_state <= RSP_NONE;
    end else begin
      rsp_state <= rsp_next;
    end
  end

  always_comb begin
    rsp_next      = RSP_NONE;
    bus.if_rvalid = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_rdata  = '0;

    if (grant_if) begin
      rsp_next = RSP_IF;
    end else if (grant_load) begin
      rsp_next = RSP_DM;
    end

    // A read issued just before reset is discarded: rst masks the response.
    if (!rst) begin
      case (rsp_state)
        RSP_IF: begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = bus.mem_read_data;
        end
        RSP_DM: begin
          bus.dm_rvalid = 1'b1;
          bus.dm_rdata  = bus.mem_read_data;
        end
        default: begin
          bus.if_rvalid = 1'b0;
          bus.dm_rvalid = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
